// File: rtl/uart_baud_frac.sv
// -----------------------------------------------------------------------------
// uart_baud_frac
//
// Fractional baud-tick generator for the UART.
//
// o_rx_tick is the receive oversampling tick. Its mean period is
// div_int + div_frac/2^FRAC_W clocks. A fraction accumulator adds the
// fractional part once per period, and each carry out of it makes the next
// period one clock longer. o_tx_tick fires together with every OVS-th
// o_rx_tick.
//
// A new divisor is first held as pending. It becomes active only at a period
// boundary, so a period that has already started always finishes with the
// divisor it started with. While the generator is disabled, there is no
// period in flight, so the hand-over happens on the next edge.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   i_en         generator enable; low holds all counters cleared
//   i_div_int    requested integer divisor (clocks per rx tick)
//   i_div_frac   requested fractional divisor (units of 1/2^FRAC_W clock)
//   i_div_load   one-cycle strobe capturing i_div_int/i_div_frac as pending
//   o_rx_tick    one-cycle oversampling tick
//   o_tx_tick    one-cycle bit tick, coincident with every OVS-th o_rx_tick
//   o_cfg_err    high while the active integer divisor is below 2 (clamped)
// -----------------------------------------------------------------------------
module uart_baud_frac #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_rx_tick,
    output logic              o_tx_tick,
    output logic              o_cfg_err
);

    localparam int                CNT_W     = DIV_W + 1;
    localparam int                OCNT_W    = $clog2(OVS);
    localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OVS - 1);
    localparam logic [DIV_W-1:0]  MIN_INT   = DIV_W'(2);

    // Active and pending divisor
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pend_vld;

    // Period machinery
    logic [CNT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_c;
    logic [OCNT_W-1:0] r_ocnt;

    // Registered outputs
    logic              r_rx_tick;
    logic              r_tx_tick;
    logic              r_cfg_err;

    logic [DIV_W-1:0]  w_eff_int;
    logic [CNT_W-1:0]  w_last;
    logic              w_boundary;
    logic [FRAC_W:0]   w_sum;
    logic              w_xfer;
    logic [DIV_W-1:0]  w_act_int_next;
    logic [FRAC_W-1:0] w_act_frac_next;

    // A divisor below 2 cannot produce a tick that is separated from the next
    // one, so the divisor is clamped to 2.
    assign w_eff_int  = (r_act_int < MIN_INT) ? MIN_INT : r_act_int;

    // Last count of this period. The pending carry lengthens the period by
    // one clock.
    assign w_last     = {1'b0, w_eff_int} + CNT_W'(r_c) - CNT_W'(1);
    assign w_boundary = i_en && (r_cnt == w_last);

    // The fraction step always uses the divisor that was active during the
    // period that is ending, including on the edge where a new one is taken.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_act_frac};

    // Hand-over of the pending divisor: at a period boundary while running,
    // or on any edge while disabled.
    assign w_xfer          = r_pend_vld && (w_boundary || !i_en);
    assign w_act_int_next  = w_xfer ? r_pend_int  : r_act_int;
    assign w_act_frac_next = w_xfer ? r_pend_frac : r_act_frac;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_int   <= DIV_W'(DEF_INT);
            r_act_frac  <= FRAC_W'(DEF_FRAC);
            r_pend_int  <= DIV_W'(DEF_INT);
            r_pend_frac <= FRAC_W'(DEF_FRAC);
            r_pend_vld  <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_c         <= 1'b0;
            r_ocnt      <= '0;
            r_rx_tick   <= 1'b0;
            r_tx_tick   <= 1'b0;
            r_cfg_err   <= (DEF_INT < 2);
        end else begin
            // The last load wins. A load on the hand-over edge stays pending
            // until the following boundary.
            if (i_div_load) begin
                r_pend_int  <= i_div_int;
                r_pend_frac <= i_div_frac;
            end
            if (i_div_load) begin
                r_pend_vld <= 1'b1;
            end else if (w_xfer) begin
                r_pend_vld <= 1'b0;
            end

            r_act_int  <= w_act_int_next;
            r_act_frac <= w_act_frac_next;
            // Computed from the next active value, so that the flag changes
            // on the same edge as the divisor it describes.
            r_cfg_err  <= (w_act_int_next < MIN_INT);

            if (!i_en) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_c       <= 1'b0;
                r_ocnt    <= '0;
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end else if (w_boundary) begin
                r_cnt        <= '0;
                {r_c, r_acc} <= w_sum;
                r_rx_tick    <= 1'b1;
                if (r_ocnt == OCNT_LAST) begin
                    r_ocnt    <= '0;
                    r_tx_tick <= 1'b1;
                end else begin
                    r_ocnt    <= r_ocnt + OCNT_W'(1);
                    r_tx_tick <= 1'b0;
                end
            end else begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_rx_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end
        end
    end

    assign o_rx_tick = r_rx_tick;
    assign o_tx_tick = r_tx_tick;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_uart_baud_frac.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_frac
//
// Directed bench for uart_baud_frac with its default parameters
// (DIV_W=16, FRAC_W=4, OVS=16, DEF_INT=27, DEF_FRAC=2).
//
// Inputs change on the falling edge and outputs are sampled on the falling
// edge. cyc counts rising edges, so the cyc value at which a tick is seen,
// minus the cyc value at which the previous tick (or the enable) was seen,
// gives the period in clocks.
// -----------------------------------------------------------------------------
module tb_uart_baud_frac;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        en       = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_int  = '0;
    logic [3:0]  div_frac = '0;
    logic        rx_tick;
    logic        tx_tick;
    logic        cfg_err;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    bit timed_out = 1'b0;

    uart_baud_frac dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (en),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .i_div_load (div_load),
        .o_rx_tick  (rx_tick),
        .o_tx_tick  (tx_tick),
        .o_cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A tx tick must always coincide with an rx tick.
    always @(negedge clk) begin
        if (!reset && tx_tick === 1'b1) check_val("tx_with_rx", longint'(rx_tick), 1);
    end

    // Waits for the next rx tick, starting at the following falling edge.
    task automatic wait_rx(output int t, output logic tx);
        t  = -1;
        tx = 1'b0;
        if (!timed_out) begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (rx_tick === 1'b1) begin
                    t  = cyc;
                    tx = tx_tick;
                    break;
                end
            end
            if (t < 0) begin
                timed_out = 1'b1;
                check_val("rx_timeout", 0, 1);
            end
        end
    endtask

    // Called on a falling edge: strobes div_load for one rising edge.
    task automatic load_div(input int vi, input int vf);
        div_int  = 16'(vi);
        div_frac = 4'(vf);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // Disable, load, and let the divisor become active while disabled.
    task automatic idle_load(input int vi, input int vf);
        en = 1'b0;
        @(negedge clk);
        load_div(vi, vf);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t, prev, c0, t1, t16, n;
        logic tx;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_val("rst_rx", longint'(rx_tick), 0);
        check_val("rst_tx", longint'(tx_tick), 0);
        check_val("rst_cfg_err", longint'(cfg_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- integer divisor 4 ----------------
        idle_load(4, 0);
        en = 1'b1; c0 = cyc; prev = c0; t16 = 0;
        for (int k = 1; k <= 32; k++) begin
            wait_rx(t, tx);
            $display("int k=%0d period=%0d tx=%0d", k, t - prev, tx);
            check_val("int_period", t - prev, 4);
            check_val("int_tx", longint'(tx), (k % 16 == 0) ? 1 : 0);
            if (k == 16) begin
                check_val("int_first_tx", t - c0, 64);
                t16 = t;
            end
            if (k == 32) check_val("int_tx_spacing", t - t16, 64);
            prev = t;
        end
        check_val("int_cfg_err", longint'(cfg_err), 0);

        // ---------------- fractional divisor 4 + 8/16 ----------------
        idle_load(4, 8);
        en = 1'b1; c0 = cyc; prev = c0; t1 = 0;
        for (int k = 1; k <= 33; k++) begin
            wait_rx(t, tx);
            $display("frac k=%0d period=%0d tx=%0d", k, t - prev, tx);
            check_val("frac_period", t - prev, (k >= 3 && k % 2 == 1) ? 5 : 4);
            check_val("frac_tx", longint'(tx), (k % 16 == 0) ? 1 : 0);
            if (k == 1) t1 = t;
            if (k == 33) check_val("frac_span32", t - t1, 144);
            prev = t;
        end

        // ---------------- mid-period load, last wins ----------------
        idle_load(10, 0);
        en = 1'b1; c0 = cyc;
        wait_rx(t, tx);
        check_val("mid_first", t - c0, 10);
        prev = t;
        repeat (3) @(negedge clk);       // cnt == 3
        load_div(13, 0);
        repeat (2) @(negedge clk);       // cnt == 6
        load_div(6, 0);
        wait_rx(t, tx);
        $display("mid inflight period=%0d", t - prev);
        check_val("mid_inflight", t - prev, 10);
        prev = t;
        for (int k = 1; k <= 3; k++) begin
            wait_rx(t, tx);
            $display("mid k=%0d period=%0d", k, t - prev);
            check_val("mid_new_period", t - prev, 6);
            prev = t;
        end

        // ---------------- enable toggle ----------------
        idle_load(8, 0);
        en = 1'b1; c0 = cyc;
        wait_rx(t, tx);
        check_val("en_first", t - c0, 8);
        repeat (5) @(negedge clk);       // cnt == 5
        en = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n += int'(rx_tick) + int'(tx_tick);
        end
        $display("en off ticks=%0d", n);
        check_val("en_off_ticks", n, 0);
        en = 1'b1; c0 = cyc; prev = c0;
        for (int k = 1; k <= 16; k++) begin
            wait_rx(t, tx);
            check_val("reen_period", t - prev, 8);
            check_val("reen_tx", longint'(tx), (k == 16) ? 1 : 0);
            if (k == 16) begin
                $display("reen first tx after %0d clocks", t - c0);
                check_val("reen_first_tx", t - c0, 128);
            end
            prev = t;
        end
        repeat (7) @(negedge clk);       // cnt == 7, the last count of the period
        en = 1'b0;
        @(negedge clk);
        check_val("en_fall_boundary", longint'(rx_tick), 0);
        @(negedge clk);

        // ---------------- clamp ----------------
        idle_load(8, 0);
        en = 1'b1;
        wait_rx(t, tx);
        prev = t;
        load_div(1, 0);
        wait_rx(t, tx);
        check_val("clamp1_inflight", t - prev, 8);
        check_val("clamp1_cfg_err", longint'(cfg_err), 1);
        prev = t;
        for (int k = 1; k <= 2; k++) begin
            wait_rx(t, tx);
            check_val("clamp1_period", t - prev, 2);
            prev = t;
        end
        load_div(0, 0);
        wait_rx(t, tx);
        check_val("clamp0_xfer_period", t - prev, 2);
        prev = t;
        for (int k = 1; k <= 2; k++) begin
            wait_rx(t, tx);
            check_val("clamp0_period", t - prev, 2);
            check_val("clamp0_cfg_err", longint'(cfg_err), 1);
            prev = t;
        end
        load_div(3, 0);
        check_val("clamp3_cfg_hold", longint'(cfg_err), 1);
        wait_rx(t, tx);
        check_val("clamp3_xfer_period", t - prev, 2);
        check_val("clamp3_cfg_err", longint'(cfg_err), 0);
        prev = t;
        wait_rx(t, tx);
        $display("clamp3 period=%0d cfg_err=%0d", t - prev, cfg_err);
        check_val("clamp3_period", t - prev, 3);
        prev = t;

        // A load on the boundary edge applies at the following boundary.
        repeat (2) @(negedge clk);       // cnt == 2, the last count of the period
        load_div(5, 0);
        check_val("bnd_load_tick", longint'(rx_tick), 1);
        prev = cyc;
        wait_rx(t, tx);
        check_val("bnd_load_old", t - prev, 3);
        prev = t;
        wait_rx(t, tx);
        check_val("bnd_load_new", t - prev, 5);

        // ---------------- reset mid-run ----------------
        idle_load(20, 5);
        en = 1'b1;
        wait_rx(t, tx);
        wait_rx(t, tx);                  // acc is non-zero from here on
        reset = 1'b1;
        #1;
        check_val("rst_mid_rx", longint'(rx_tick), 0);
        check_val("rst_mid_tx", longint'(tx_tick), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; c0 = cyc; prev = c0;
        for (int k = 1; k <= 9; k++) begin
            wait_rx(t, tx);
            $display("post-reset k=%0d period=%0d", k, t - prev);
            check_val("rst_period", t - prev, (k == 9) ? 28 : 27);
            prev = t;
        end
        check_val("rst_cfg_err_after", longint'(cfg_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
